// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage between execute and write-back.
//            Registers the execute->memory bus and performs word loads and
//            stores over a request/grant/response data-memory port. While an
//            access is outstanding it stalls the upstream pipeline. It drives
//            the memory->write-back bus and a forwarding bus back to decode.
// Ports    : clk, rst_n          - clock, async active-low reset
//            exe_mem_bus_in      - 155-bit bus from execute
//            mem_stall           - upstream must hold its bus
//            mem_wb_bus_out      - 154-bit bus to write-back
//            mem_id_data_bus     - {fwd_data, fwd_wen, rd} to decode
//            dmem_req/we/addr/wdata, dmem_gnt, dmem_rvalid, dmem_rdata
//                                - data-memory handshake port
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [154:0] exe_mem_bus_in,
   output logic         mem_stall,
   output logic [153:0] mem_wb_bus_out,
   output logic [37:0]  mem_id_data_bus,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [31:0]  dmem_addr,
   output logic [31:0]  dmem_wdata,
   input  logic         dmem_gnt,
   input  logic         dmem_rvalid,
   input  logic [31:0]  dmem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [154:0]  r_ex;
   logic [31:0]   r_rdata;

   // Field views of the registered execute bus
   logic [31:0]   w_alu;
   logic [4:0]    w_rd;
   logic          w_rd_wen;
   logic          w_mem_we;
   logic          w_mem_re;
   logic [2:0]    w_wb_sel;
   logic [31:0]   w_pc;
   logic [31:0]   w_store_data;
   logic [3:0]    w_csr_cmd;
   logic [11:0]   w_csr_addr;
   logic [31:0]   w_op1;

   assign {w_alu, w_rd, w_rd_wen, w_mem_we, w_mem_re, w_wb_sel, w_pc,
           w_store_data, w_csr_cmd, w_csr_addr, w_op1} = r_ex;

   logic          w_access;
   logic          w_misalign;
   logic          w_aligned_access;
   logic          w_out_wen;
   logic [31:0]   w_load_data;
   logic [31:0]   w_fwd_data;

   assign w_access         = w_mem_we | w_mem_re;
   assign w_misalign       = w_access & (w_alu[1:0] != 2'b00);
   assign w_aligned_access = w_access & ~w_misalign;

   // Request and stall must react to the grant within the same cycle, so
   // they are decoded from the current state rather than registered.
   always_comb begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      case (r_state)
         ST_IDLE: begin
            dmem_req  = w_aligned_access;
            // A granted store retires now; an ungranted request or a granted
            // load (still waiting for data) holds the pipeline.
            mem_stall = w_aligned_access & (~dmem_gnt | ~w_mem_we);
         end
         ST_WAIT: begin
            mem_stall = 1'b1;
         end
         default: begin
            mem_stall = 1'b0;
         end
      endcase
   end

   assign dmem_we    = w_mem_we;
   assign dmem_addr  = {w_alu[31:2], 2'b00};
   assign dmem_wdata = w_store_data;

   assign w_load_data = (r_state == ST_DONE) ? r_rdata : 32'd0;
   assign w_fwd_data  = (r_state == ST_DONE) ? r_rdata : w_alu;
   // Stall cycles present a bubble; misaligned accesses never write back.
   assign w_out_wen   = w_rd_wen & ~w_misalign & ~mem_stall;

   assign mem_wb_bus_out  = {w_rd, w_out_wen, w_wb_sel, w_pc, w_alu,
                             w_load_data, w_misalign, w_csr_cmd, w_csr_addr,
                             w_op1};
   assign mem_id_data_bus = {w_fwd_data, w_out_wen, w_rd};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex <= '0;
      end else if (!mem_stall) begin
         r_ex <= exe_mem_bus_in;
      end
   end

   // Access FSM. Reset returns to IDLE, which drops any outstanding request
   // and makes a late response irrelevant (rvalid only matters in WAIT).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_aligned_access && dmem_gnt && !w_mem_we) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dmem_rvalid) begin
                  r_rdata <= dmem_rdata;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Directed steps drive the
//            execute bus, a small memory responder answers the dmem port,
//            and a scoreboard checks every retired instruction in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [154:0] exe_mem_bus_in = '0;
   logic         mem_stall;
   logic [153:0] mem_wb_bus_out;
   logic [37:0]  mem_id_data_bus;
   logic         dmem_req;
   logic         dmem_we;
   logic [31:0]  dmem_addr;
   logic [31:0]  dmem_wdata;
   logic         dmem_gnt = 1'b0;
   logic         dmem_rvalid = 1'b0;
   logic [31:0]  dmem_rdata = 32'd0;

   mem_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .exe_mem_bus_in  (exe_mem_bus_in),
      .mem_stall       (mem_stall),
      .mem_wb_bus_out  (mem_wb_bus_out),
      .mem_id_data_bus (mem_id_data_bus),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_gnt        (dmem_gnt),
      .dmem_rvalid     (dmem_rvalid),
      .dmem_rdata      (dmem_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   int          gnt_delay = 0;
   int          rv_delay  = 1;
   logic [31:0] rdata_cfg = 32'd0;
   int          m_req_cnt = 0;
   logic        rv_pend   = 1'b0;
   int          rv_cnt    = 0;
   logic [31:0] rv_data   = 32'd0;
   int          wr_count  = 0;
   logic [31:0] wr_addr   = 32'd0;
   logic [31:0] wr_data   = 32'd0;

   always @(negedge clk) begin
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (!rst_n) m_req_cnt = 0;
      if (rv_pend) begin
         if (rv_cnt == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rv_data;
            rv_pend     = 1'b0;
         end else begin
            rv_cnt--;
         end
      end else if (dmem_req) begin
         if (m_req_cnt == gnt_delay) begin
            dmem_gnt  = 1'b1;
            m_req_cnt = 0;
            if (dmem_we) begin
               wr_count++;
               wr_addr = dmem_addr;
               wr_data = dmem_wdata;
            end else begin
               rv_pend = 1'b1;
               rv_cnt  = rv_delay - 1;
               rv_data = rdata_cfg;
            end
         end else begin
            m_req_cnt++;
         end
      end
   end

   // ---------------- scoreboard and monitor ----------------
   logic [191:0] sb[$];
   int stall_cnt = 0;
   int req_cnt = 0;
   int req_stall_cnt = 0;
   int cyc = 0;
   int last_ret = 0;
   int prev_ret = 0;

   function automatic logic [154:0] mk(input logic [31:0] alu, input logic [4:0] rd,
                                       input logic wen, input logic we, input logic re,
                                       input logic [31:0] pc, input logic [31:0] sd);
      return {alu, rd, wen, we, re, 3'd1, pc, sd, 4'h3, pc[11:0], ~alu};
   endfunction

   function automatic logic [191:0] expect_of(input logic [154:0] b, input logic [31:0] ld);
      logic [31:0] alu, pc, op1, lda, fwd;
      logic [4:0]  rd;
      logic [2:0]  wbs;
      logic [3:0]  csrc;
      logic [11:0] csra;
      logic        wen, we, re, mis, isload, owen;
      alu = b[154:123]; rd = b[122:118]; wen = b[117]; we = b[116]; re = b[115];
      wbs = b[114:112]; pc = b[111:80]; csrc = b[47:44]; csra = b[43:32]; op1 = b[31:0];
      mis    = (we | re) && (alu[1:0] != 2'b00);
      isload = re & ~we & ~mis;
      owen   = wen & ~mis;
      lda    = isload ? ld : 32'd0;
      fwd    = isload ? ld : alu;
      return {rd, owen, wbs, pc, alu, lda, mis, csrc, csra, op1, fwd, owen, rd};
   endfunction

   always @(negedge clk) begin
      logic [191:0] e;
      #2;
      cyc++;
      if (rst_n) begin
         if (dmem_req) req_cnt++;
         if (mem_stall) begin
            stall_cnt++;
            if (dmem_req) req_stall_cnt++;
            chk("bubble_wen", mem_wb_bus_out[148], 1'b0);
         end
         if (!mem_stall && mem_wb_bus_out[144:113] != 32'd0) begin
            if (sb.size() == 0) begin
               chk("unexpected_retire", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("wb_bus", mem_wb_bus_out, e[191:38]);
               chk("fwd_bus", mem_id_data_bus, e[37:0]);
               prev_ret = last_ret;
               last_ret = cyc;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [154:0] b, input logic [31:0] ld);
      int n;
      @(negedge clk);
      exe_mem_bus_in = b;
      sb.push_back(expect_of(b, ld));
      #1;
      n = 0;
      while (mem_stall && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) chk("issue_timeout", 1, 0);
      @(posedge clk);
   endtask

   task automatic drain();
      int n;
      @(negedge clk);
      exe_mem_bus_in = '0;
      #3;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (n >= 50) chk("drain_timeout", 1, 0);
   endtask

   task automatic clr();
      stall_cnt = 0; req_cnt = 0; req_stall_cnt = 0; wr_count = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [159:0] rnd;
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      #1;
      rst_n = 1'b0;
      exe_mem_bus_in = rnd[154:0];
      repeat (3) @(negedge clk);
      #1;
      chk("rst_wb", mem_wb_bus_out, 0);
      chk("rst_id", mem_id_data_bus, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_addr", {dmem_we, dmem_addr, dmem_wdata}, 0);

      // release with an ALU op
      @(negedge clk);
      exe_mem_bus_in = '0;
      rst_n = 1'b1;
      clr();
      issue(mk(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1000, 32'd0), 32'd0);
      drain();
      chk("alu_nostall", stall_cnt, 0);

      // store with grant after three waiting cycles
      gnt_delay = 3;
      clr();
      issue(mk(32'h100, 5'd0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'hDEADBEEF), 32'd0);
      drain();
      gnt_delay = 0;
      chk("st_req_stall", req_stall_cnt, 3);
      chk("st_req_total", req_cnt, 4);
      chk("st_writes", wr_count, 1);
      chk("st_wr", {wr_addr, wr_data}, {32'h100, 32'hDEADBEEF});

      // load, immediate grant, data two cycles later
      rv_delay = 2;
      rdata_cfg = 32'hCAFEF00D;
      clr();
      issue(mk(32'h200, 5'd7, 1'b1, 1'b0, 1'b1, 32'h3000, 32'd0), 32'hCAFEF00D);
      drain();
      chk("ld_stalls", stall_cnt, 3);

      // misaligned load
      clr();
      issue(mk(32'h203, 5'd8, 1'b1, 1'b0, 1'b1, 32'h4000, 32'd0), 32'd0);
      drain();
      chk("mis_req", req_cnt, 0);
      chk("mis_stall", stall_cnt, 0);

      // both we and re set: treated as a store
      clr();
      issue(mk(32'h300, 5'd9, 1'b1, 1'b1, 1'b1, 32'h5000, 32'h55AA55AA), 32'hCAFEF00D);
      drain();
      chk("both_writes", wr_count, 1);
      chk("both_wdata", wr_data, 32'h55AA55AA);

      // back-to-back load then ALU op
      rv_delay = 1;
      rdata_cfg = 32'h13572468;
      clr();
      issue(mk(32'h400, 5'd10, 1'b1, 1'b0, 1'b1, 32'h6000, 32'd0), 32'h13572468);
      issue(mk(32'hABCD0, 5'd11, 1'b1, 1'b0, 1'b0, 32'h6004, 32'd0), 32'd0);
      drain();
      chk("b2b_stalls", stall_cnt, 2);
      chk("b2b_gap", last_ret - prev_ret, 1);

      // reset while waiting for load data
      rv_delay = 4;
      rdata_cfg = 32'hBAD0BAD0;
      issue(mk(32'h500, 5'd12, 1'b1, 1'b0, 1'b1, 32'h7000, 32'd0), 32'hBAD0BAD0);
      @(negedge clk);
      exe_mem_bus_in = '0;
      @(negedge clk);
      #1;
      chk("wait_stall", {dmem_req, mem_stall}, 2'b01);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req", dmem_req, 0);
      chk("rst_mid_stall", mem_stall, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      clr();
      repeat (4) @(negedge clk);
      #3;
      chk("late_rv_stall", stall_cnt, 0);
      chk("late_rv_fwd", mem_id_data_bus, 0);
      issue(mk(32'h777, 5'd13, 1'b1, 1'b0, 1'b0, 32'h8000, 32'd0), 32'd0);
      drain();
      chk("post_rst_stall", stall_cnt, 0);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. Registers the 155-bit execute→memory bus, performs word-sized loads and stores on a data-memory port with a request/grant/response handshake, stalls the upstream pipeline while an access is outstanding, and produces the memory→write-back bus and a forwarding bus for decode.

## Interface
- Parameters: none.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `exe_mem_bus_in`  in  155  `{alu_result[31:0], rd[4:0], rd_wen, mem_we, mem_re, wb_sel[2:0], pc[31:0], store_data[31:0], csr_cmd[3:0], csr_addr[11:0], op1[31:0]}`, MSB first.
- `mem_stall`  out  1  upstream must hold its bus; input register does not capture.
- `mem_wb_bus_out`  out  154  `{rd, rd_wen, wb_sel, pc, alu_result, load_data[31:0], misalign, csr_cmd, csr_addr, op1}`.
- `mem_id_data_bus`  out  38  `{fwd_data[31:0], fwd_wen, rd[4:0]}`.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  `alu_result`, word-aligned.
- `dmem_wdata`  out  32  `store_data`.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  32  load data.

## Operation
- Input register `ex_r` (155 b) captures `exe_mem_bus_in` on every rising edge where `mem_stall`=0; holds otherwise.
- Access = `ex_r.mem_we | ex_r.mem_re`. `mem_we` has priority when both are set (treated as store; `load_data`=0).
- Misaligned: access with `alu_result[1:0]`≠0 → no request, no stall, `misalign`=1, `rd_wen` forced 0 on output.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, aligned access: `dmem_req`=1. No `dmem_gnt` → stay, `mem_stall`=1. Store with `gnt` → retire this cycle, `mem_stall`=0, stay IDLE. Load with `gnt` → WAIT, `mem_stall`=1.
  - IDLE, no access or misaligned: retire this cycle, `mem_stall`=0.
  - WAIT: `dmem_req`=0, `mem_stall`=1; on `dmem_rvalid` capture `dmem_rdata` into `rdata_r`, go DONE.
  - DONE: `mem_stall`=0; retire load with `load_data`=`rdata_r`; next state IDLE.
- `dmem_rvalid` outside WAIT is ignored; `dmem_gnt` when `dmem_req`=0 is ignored.
- Output bus carries `ex_r` fields when retiring; while `mem_stall`=1 it is a bubble: `rd_wen`=0, other fields don't-care.
- `load_data`=`rdata_r` in DONE, else 0.
- Forwarding: `fwd_data` = `rdata_r` in DONE, else `alu_result`; `fwd_wen` = output `rd_wen`; `rd` = `ex_r.rd`.
- `dmem_addr`/`dmem_wdata`/`dmem_we` come from `ex_r` and are stable while `dmem_req`=1.

## Timing
- Reset (async, immediate): `ex_r`=0, state IDLE, `rdata_r`=0. All outputs therefore 0, including `dmem_req` and `mem_stall`.
- Non-memory and misaligned instructions: 0 added latency; they are visible on `mem_wb_bus_out` the cycle after capture.
- Store: retires in the cycle `gnt` is seen. 0 stall cycles if `gnt` is immediate.
- Load: the earliest response is one cycle after `gnt`.
  - Minimum is 2 stall cycles: the grant cycle and the rvalid cycle. Retirement happens in the DONE cycle.
- Reset mid-access: the request drops immediately, and the outstanding response is dropped.
  - The memory side must discard any pending rvalid.

## Test plan
- Reset: hold `rst_n`=0 with a random bus → all outputs 0. Release with an ALU op `rd`=5, `alu_result`=0x1234 → `mem_wb_bus_out` shows rd 5, `rd_wen`=1 next cycle, with `mem_stall` never high.
- Store, `gnt` after 3 cycles at addr 0x100, data 0xDEADBEEF → `dmem_req` high for 3 cycles with `mem_stall`=1, then low after the `gnt` cycle. The write is seen once.
- Load at addr 0x200, `gnt` immediate, `rvalid` 2 cycles later with 0xCAFEF00D → `load_data`=0xCAFEF00D in DONE. `fwd_data` matches, and 3 stall cycles are seen.
- Misaligned load at addr 0x203 → no `dmem_req`, `misalign`=1, `rd_wen`=0, no stall.
- Back-to-back load then ALU op → the ALU op stays held upstream until the load retires. It then retires on the next cycle in order.
- Reset asserted in WAIT → `dmem_req`/`mem_stall` go to 0 immediately. A late `rvalid` after release is ignored.
